ladybird_bus_arbiter: RTL and testbench
=======================================

# ladybird_bus_arbiter

Two-requester arbiter that shares one memory bus between the core's instruction-fetch port (requester 0) and its data/MMU port (requester 1). Arbitration is round-robin with a lock-until-accepted rule. An owner FIFO tracks outstanding transactions, so in-order responses (`data_gnt`, `rdata`) are routed back to the requester that issued them. The block sits between the core/MMU and the single shared memory or bus bridge.

## Interface
- `XLEN`, 32: address and data width.
- `DEPTH`, 4: maximum outstanding transactions (owner FIFO depth); power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `anrst` in 1: reset, asynchronous and active-low; clears all state.
- `req0`/`req1` in 1: requester issues a transaction; addr/wdata/wstrb held stable until `gntN`.
- `addr0`/`addr1` in XLEN: byte address.
- `wdata0`/`wdata1` in XLEN: store data.
- `wstrb0`/`wstrb1` in XLEN/8: byte strobes; all-zero means read.
- `gnt0`/`gnt1` out 1: request accepted this cycle.
- `data_gnt0`/`data_gnt1` out 1: response for this requester valid this cycle.
- `rdata0`/`rdata1` out XLEN: response data; both are driven with `m_rdata` unconditionally.
- `m_req` out 1: downstream request.
- `m_addr`, `m_wdata`, `m_wstrb` out: muxed request fields from the selected requester.
- `m_gnt` in 1: downstream accepted the request.
- `m_data_gnt` in 1: downstream response valid. Exactly one response per accepted transaction, reads and writes alike, in order.
- `m_rdata` in XLEN: downstream response data.
- `outstanding` out $clog2(DEPTH)+1: current FIFO occupancy.
- `err` out 1: sticky flag; a response arrived with an empty FIFO.

## Operation
- Selection:
  - If `lock` is set, `sel = lock_id`.
  - Else if exactly one `reqN` is high, `sel = N`.
  - Else if both are high, `sel` is the requester not equal to `last` (round-robin).
  - If neither is high, `m_req` = 0.
- Downstream request: `m_req = req_sel & ~full`. `m_addr`, `m_wdata` and `m_wstrb` are muxed from `sel`; when idle they carry requester 0's fields.
- Accept: `accept = m_req & m_gnt`. Then `gnt_sel` = 1 combinationally and the other gnt = 0. On accept:
  - push `sel` into the owner FIFO;
  - `last <= sel`;
  - `lock <= 0`.
- Lock: when `m_req` = 1 and `m_gnt` = 0, `lock <= 1` and `lock_id <= sel`. Selection is then frozen until accept, so the downstream request fields never switch mid-handshake.
- Full: occupancy == DEPTH forces `m_req` = 0, even if a pop happens the same cycle (no `m_data_gnt` → `m_gnt` path). `lock` is unaffected by full.
- Response, FIFO not empty: on `m_data_gnt`, `data_gnt[head]` = 1 combinationally, then pop.
- Response, FIFO empty: on `m_data_gnt`, both `data_gnt` outputs stay 0, `err <= 1`, no pop.
- Simultaneous push and pop: occupancy unchanged; head and tail pointers both advance, modulo DEPTH with wrap.
- Pointers: $clog2(DEPTH) bits each, wrapping naturally. The occupancy counter is separate.
- A requester may drop `req` only after `gnt`. Dropping it earlier while locked is a protocol violation and the behaviour is undefined.

## Timing
- Reset values:
  - `m_req`, `gnt0`, `gnt1`, `data_gnt0`, `data_gnt1` = 0;
  - `outstanding` = 0, `err` = 0;
  - `lock` = 0, `last` = 1, so requester 0 wins the first tie;
  - FIFO pointers = 0.
- Zero-cycle request path: `req` → `m_req` and `m_gnt` → `gnt` are combinational. Back-to-back accepts are allowed every cycle.
- Zero-cycle response path: `m_data_gnt` → `data_gntN` is combinational. The response may arrive in the cycle after its accept at the earliest. It cannot arrive in the accept cycle, because the FIFO push is registered.
- `outstanding` and `err` update on the clock edge after the event.
- Reset asserted mid-transaction clears the FIFO and lock immediately (async). The downstream must be reset in the same domain; any responses that arrive late set `err`.

## Test plan
- Single reader: `req0` addr 0x100, `m_gnt` = 1 in cycle 0, `m_data_gnt` in cycle 2 with rdata 0xDEADBEEF → `gnt0` in cycle 0, `data_gnt0` in cycle 2 with `rdata0` = 0xDEADBEEF, `outstanding` 1→0.
- Tie round-robin: `req0` and `req1` held high, `m_gnt` = 1 every cycle, responses streaming → grants alternate 0,1,0,1 starting with 0 after reset. Responses route in the same order.
- Lock: `req0` (addr 0x10) and `req1` both high, `m_gnt` = 0 for 3 cycles, then 1 → `m_addr` stays 0x10 throughout and `gnt0` fires on cycle 3. The next grant goes to requester 1.
- Full: DEPTH = 4, four accepts with no responses → `outstanding` = 4 and `m_req` = 0. A pop that cycle still blocks the push. The next cycle, `m_req` = 1 again.
- Push and pop together: occupancy 2, accept plus `m_data_gnt` in one cycle → occupancy stays 2 and the correct owner receives `data_gnt`. Pointer wrap is verified over 10 transactions.
- Error and reset: `m_data_gnt` with empty FIFO → `err` = 1, no `data_gnt`. Then assert `anrst` with 3 outstanding → `err` = 0, `outstanding` = 0, `lock` = 0 asynchronously.

Source files
------------

// File: rtl/ladybird_bus_arbiter.sv
// Purpose : round-robin arbiter sharing one memory bus between fetch (req 0) and data/MMU (req 1),
//           with an owner FIFO that routes in-order responses back to the requester that issued them.
// Latency : zero-cycle request path (req->m_req, m_gnt->gnt) and response path (m_data_gnt->data_gnt).
// Backpressure: m_gnt low holds the winner locked until accepted; DEPTH outstanding blocks new requests.
//
// Ports:
//   clk, anrst                 clock, async active-low reset
//   reqN/addrN/wdataN/wstrbN   requester N transaction (fields stable until gntN)
//   gntN                       requester N accepted this cycle
//   data_gntN, rdataN          response for requester N (rdataN always mirrors m_rdata)
//   m_req/m_addr/m_wdata/m_wstrb, m_gnt          downstream request handshake
//   m_data_gnt, m_rdata        downstream in-order response
//   outstanding                owner FIFO occupancy
//   err                        sticky: response seen with no transaction outstanding
module ladybird_bus_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     anrst,
  input  logic                     req0,
  input  logic [XLEN-1:0]          addr0,
  input  logic [XLEN-1:0]          wdata0,
  input  logic [XLEN/8-1:0]        wstrb0,
  input  logic                     req1,
  input  logic [XLEN-1:0]          addr1,
  input  logic [XLEN-1:0]          wdata1,
  input  logic [XLEN/8-1:0]        wstrb1,
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     data_gnt0,
  output logic                     data_gnt1,
  output logic [XLEN-1:0]          rdata0,
  output logic [XLEN-1:0]          rdata1,
  output logic                     m_req,
  output logic [XLEN-1:0]          m_addr,
  output logic [XLEN-1:0]          m_wdata,
  output logic [XLEN/8-1:0]        m_wstrb,
  input  logic                     m_gnt,
  input  logic                     m_data_gnt,
  input  logic [XLEN-1:0]          m_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  // Lock state: once a request is presented but not accepted, selection freezes
  // so the downstream never sees the request fields change mid-handshake.
  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

  arb_state_e        state_q, state_d;
  logic              lock_id_q, lock_id_d;
  logic              last_q, last_d;
  logic [DEPTH-1:0]  owner_q;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic sel;
  logic req_sel;
  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic head_owner;

  // Requester selection
  always_comb begin
    sel = 1'b0;
    if (state_q == ARB_LOCKED) begin
      sel = lock_id_q;
    end else if (req0 && req1) begin
      sel = ~last_q;
    end else if (req1) begin
      sel = 1'b1;
    end
  end

  assign req_sel    = sel ? req1 : req0;
  assign full       = (cnt_q == CNT_MAX);
  assign empty      = (cnt_q == '0);
  // Full blocks the push even if a pop lands this cycle: no m_data_gnt -> m_gnt path.
  assign m_req      = req_sel & ~full;
  assign accept     = m_req & m_gnt;
  assign pop        = m_data_gnt & ~empty;
  assign head_owner = owner_q[head_q];

  assign m_addr  = sel ? addr1  : addr0;
  assign m_wdata = sel ? wdata1 : wdata0;
  assign m_wstrb = sel ? wstrb1 : wstrb0;

  assign gnt0 = accept & ~sel;
  assign gnt1 = accept &  sel;

  assign data_gnt0 = pop & ~head_owner;
  assign data_gnt1 = pop &  head_owner;
  assign rdata0    = m_rdata;
  assign rdata1    = m_rdata;

  assign outstanding = cnt_q;
  assign err         = err_q;

  // Lock FSM next state
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      state_d = ARB_OPEN;
    end else if (m_req) begin
      state_d   = ARB_LOCKED;
      lock_id_d = sel;
    end
  end

  // FIFO bookkeeping, round-robin history and error flag
  always_comb begin
    last_d = last_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (m_data_gnt & empty);
    if (accept) begin
      last_d = sel;
      tail_d = tail_q + PTR_ONE;
    end
    if (pop) begin
      head_d = head_q + PTR_ONE;
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= 1'b0;
      last_q    <= 1'b1;
      head_q    <= '0;
      tail_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      if (accept) begin
        owner_q[tail_q] <= sel;
      end
    end
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
module tb_ladybird_bus_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int SW    = XLEN / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            anrst;
  logic            req0, req1;
  logic [XLEN-1:0] addr0, addr1, wdata0, wdata1;
  logic [SW-1:0]   wstrb0, wstrb1;
  logic            gnt0, gnt1, data_gnt0, data_gnt1;
  logic [XLEN-1:0] rdata0, rdata1;
  logic            m_req;
  logic [XLEN-1:0] m_addr, m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_gnt, m_data_gnt;
  logic [XLEN-1:0] m_rdata;
  logic [$clog2(DEPTH):0] outstanding;
  logic            err;

  ladybird_bus_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .anrst(anrst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .wstrb0(wstrb0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .wstrb1(wstrb1),
    .gnt0(gnt0), .gnt1(gnt1), .data_gnt0(data_gnt0), .data_gnt1(data_gnt1),
    .rdata0(rdata0), .rdata1(rdata1),
    .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_gnt(m_gnt), .m_data_gnt(m_data_gnt), .m_rdata(m_rdata),
    .outstanding(outstanding), .err(err)
  );

  typedef struct {
    int              owner;
    logic [XLEN-1:0] rdata;
  } resp_t;

  resp_t           exp_q[$];   // scoreboard: expected responses in issue order
  logic [XLEN-1:0] mem_q[$];   // downstream model: data it will return, in order
  resp_t           mon_e;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int  mcnt;
  int  mlast;
  bit  mlock;
  int  mlock_id;
  bit  merr;
  bit  use_fixed;
  logic [XLEN-1:0] fixed_rd;

  // Requester state: a pending request is held until granted
  bit              r_act[2];
  logic [XLEN-1:0] r_addr[2];
  logic [XLEN-1:0] r_wdata[2];
  logic [SW-1:0]   r_wstrb[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic new_req(input int n, input logic [XLEN-1:0] a);
    r_act[n]   = 1'b1;
    r_addr[n]  = a;
    r_wdata[n] = $urandom;
    r_wstrb[n] = ($urandom_range(0, 2) == 0) ? '0 : SW'($urandom);
  endtask

  task automatic model_reset();
    mcnt = 0; mlast = 1; mlock = 0; mlock_id = 0; merr = 0;
    r_act[0] = 0; r_act[1] = 0;
    exp_q.delete();
    mem_q.delete();
  endtask

  // Asynchronous reset asserted mid-cycle; state must clear without a clock edge.
  task automatic apply_reset();
    @(posedge clk); #1;
    anrst = 1'b0;
    req0 = 0; req1 = 0; m_gnt = 0; m_data_gnt = 0;
    #1;
    chk("rst_m_req", m_req, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_data_gnt0", data_gnt0, 0);
    chk("rst_data_gnt1", data_gnt1, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 anrst = 1'b1;
  endtask

  // One bus cycle: drive, check combinational outputs against the model, advance the model.
  task automatic step(input bit mg, input bit mdg);
    int w;
    bit full, exp_mreq, exp_acc, resp_ok;
    logic [XLEN-1:0] rd;
    @(posedge clk); #1;
    req0 = r_act[0]; addr0 = r_addr[0]; wdata0 = r_wdata[0]; wstrb0 = r_wstrb[0];
    req1 = r_act[1]; addr1 = r_addr[1]; wdata1 = r_wdata[1]; wstrb1 = r_wstrb[1];
    m_gnt = mg;
    m_data_gnt = mdg;
    resp_ok = mdg && (mem_q.size() > 0);
    m_rdata = resp_ok ? mem_q[0] : $urandom;
    #1;
    if (mlock)                      w = mlock_id;
    else if (r_act[0] && r_act[1])  w = 1 - mlast;
    else if (r_act[0])              w = 0;
    else if (r_act[1])              w = 1;
    else                            w = -1;
    full     = (mcnt == DEPTH);
    exp_mreq = (w >= 0) && !full;
    exp_acc  = exp_mreq && mg;
    chk("m_req", m_req, exp_mreq);
    chk("gnt0", gnt0, exp_acc && (w == 0));
    chk("gnt1", gnt1, exp_acc && (w == 1));
    chk("outstanding", outstanding, mcnt);
    chk("err", err, merr);
    chk("data_gnt_present", data_gnt0 | data_gnt1, resp_ok);
    if (exp_mreq) begin
      chk("m_addr", m_addr, r_addr[w]);
      chk("m_wdata", m_wdata, r_wdata[w]);
      chk("m_wstrb", m_wstrb, r_wstrb[w]);
    end
    if (resp_ok) void'(mem_q.pop_front());
    else if (mdg) merr = 1;
    if (exp_acc) begin
      rd = use_fixed ? fixed_rd : $urandom;
      mem_q.push_back(rd);
      exp_q.push_back('{w, rd});
      mlast = w;
      mlock = 0;
      r_act[w] = 0;
    end else if (exp_mreq) begin
      mlock = 1;
      mlock_id = w;
    end
    mcnt = mcnt + (exp_acc ? 1 : 0) - (resp_ok ? 1 : 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mem_q.size() > 0; i++) step(0, 1);
  endtask

  // Monitor: whenever the DUT presents a response, pop the scoreboard and compare.
  initial begin
    forever begin
      @(posedge clk); #3;
      if (anrst === 1'b1 && (data_gnt0 === 1'b1 || data_gnt1 === 1'b1)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got data_gnt0=%0b data_gnt1=%0b expected none", data_gnt0, data_gnt1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_owner0", data_gnt0, mon_e.owner == 0);
          chk("resp_owner1", data_gnt1, mon_e.owner == 1);
          chk("rdata0", rdata0, mon_e.rdata);
          chk("rdata1", rdata1, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    anrst = 1'b1; req0 = 0; req1 = 0; m_gnt = 0; m_data_gnt = 0; m_rdata = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wstrb0 = '0; wstrb1 = '0;
    for (int n = 0; n < 2; n++) begin
      r_addr[n] = '0; r_wdata[n] = '0; r_wstrb[n] = '0;
    end
    use_fixed = 0; fixed_rd = '0;
    model_reset();
    apply_reset();

    // Single reader: accept in cycle 0, response in cycle 2 with a fixed word.
    use_fixed = 1; fixed_rd = 32'hDEADBEEF;
    new_req(0, 32'h100); r_wstrb[0] = '0;
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 0);
    use_fixed = 0;

    // Tie round-robin from reset: both held high, grants every cycle, responses streaming.
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      for (int n = 0; n < 2; n++) if (!r_act[n]) new_req(n, $urandom);
      step(1, mem_q.size() > 0);
    end
    drain();

    // Lock: downstream stalls three cycles; winner and its fields stay put, then the other side wins.
    new_req(0, 32'h10);
    new_req(1, 32'h20);
    step(0, 0); step(0, 0); step(0, 0);
    step(1, 0);
    new_req(0, 32'h30);
    step(1, 0);
    step(1, 0);
    drain();

    // Full: four accepts, then a pop in the full cycle must not admit a push.
    for (int c = 0; c < DEPTH; c++) begin
      new_req(0, 32'h1000 + 32'(c * 4));
      step(1, 0);
    end
    new_req(0, 32'h2000);
    step(1, 1);
    step(1, 0);
    drain();

    // Push and pop in the same cycle at occupancy 2.
    new_req(0, 32'h40); step(1, 0);
    new_req(1, 32'h44); step(1, 0);
    new_req(0, 32'h48); step(1, 1);
    step(0, 0);
    drain();

    // Randomized traffic: exercises pointer wrap, mixed reads/writes, stalls.
    for (int c = 0; c < 500; c++) begin
      for (int n = 0; n < 2; n++)
        if (!r_act[n] && $urandom_range(0, 99) < 50) new_req(n, $urandom);
      step($urandom_range(0, 99) < 60, (mem_q.size() > 0) && ($urandom_range(0, 99) < 45));
    end
    r_act[0] = 0; r_act[1] = 0;
    step(0, 0);
    for (int c = 0; c < 4 && mlock; c++) step(1, 0);
    drain();
    step(0, 0);

    // Response with nothing outstanding sets the sticky error, no data_gnt.
    step(0, 1);
    step(0, 0);

    // Reset with three outstanding and a lock held on requester 1.
    for (int c = 0; c < 3; c++) begin
      new_req(0, 32'h300 + 32'(c * 4));
      step(1, 0);
    end
    new_req(1, 32'h400);
    step(0, 0);
    apply_reset();
    new_req(0, 32'h500);
    step(1, 0);
    step(0, 1);
    step(0, 0);

    @(posedge clk); #5;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
